// File: rtl/serial_shares_words_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_shares_words_sequencer
// Description : Walks (share, word) index pairs in share-major or word-major
//               order, one position per accepted inc, with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shares_words_sequencer #(
    parameter int NBITS               = 4,
    parameter int MAX_WORDS_PER_SHARE = 8,
    parameter int d                   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               inc,
    input  logic               mode,
    input  logic [NBITS-1:0]   words_per_share_bound,
    output logic [NBITS-1:0]   share_idx,
    output logic [NBITS-1:0]   word_idx,
    output logic [2*NBITS-1:0] step_cnt,
    output logic               last_word,
    output logic               last_share,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam logic [NBITS-1:0] c_last_share = NBITS'(d - 1);
    localparam logic [NBITS-1:0] c_max_bound  = NBITS'(MAX_WORDS_PER_SHARE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   share_idx_q, share_idx_d;
    logic [NBITS-1:0]   word_idx_q, word_idx_d;
    logic [2*NBITS-1:0] step_cnt_q, step_cnt_d;
    logic               mode_q, mode_d;
    logic [NBITS-1:0]   bound_q, bound_d;
    logic               done_q, done_d;
    logic [NBITS-1:0]   eff_bound;

    assign eff_bound  = (words_per_share_bound > c_max_bound) ? c_max_bound
                                                               : words_per_share_bound;

    assign busy       = (state_q == RUN);
    assign last_word  = busy && (word_idx_q == bound_q);
    assign last_share = busy && (share_idx_q == c_last_share);
    assign last       = last_word && last_share;

    assign share_idx  = share_idx_q;
    assign word_idx   = word_idx_q;
    assign step_cnt   = step_cnt_q;
    assign done       = done_q;

    always_comb begin
        state_d     = state_q;
        share_idx_d = share_idx_q;
        word_idx_d  = word_idx_q;
        step_cnt_d  = step_cnt_q;
        mode_d      = mode_q;
        bound_d     = bound_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    mode_d      = mode;
                    bound_d     = eff_bound;
                    share_idx_d = '0;
                    word_idx_d  = '0;
                    step_cnt_d  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    share_idx_d = '0;
                    word_idx_d  = '0;
                end else if (inc) begin
                    step_cnt_d = step_cnt_q + (2*NBITS)'(1);
                    if (last) begin
                        state_d     = IDLE;
                        share_idx_d = '0;
                        word_idx_d  = '0;
                        done_d      = 1'b1;
                    end else if (!mode_q) begin
                        // Share-major: word index is the inner loop
                        if (last_word) begin
                            word_idx_d  = '0;
                            share_idx_d = share_idx_q + NBITS'(1);
                        end else begin
                            word_idx_d  = word_idx_q + NBITS'(1);
                        end
                    end else begin
                        if (last_share) begin
                            share_idx_d = '0;
                            word_idx_d  = word_idx_q + NBITS'(1);
                        end else begin
                            share_idx_d = share_idx_q + NBITS'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            share_idx_q <= '0;
            word_idx_q  <= '0;
            step_cnt_q  <= '0;
            mode_q      <= 1'b0;
            bound_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            share_idx_q <= share_idx_d;
            word_idx_q  <= word_idx_d;
            step_cnt_q  <= step_cnt_d;
            mode_q      <= mode_d;
            bound_q     <= bound_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_shares_words_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_shares_words_sequencer
// Description : Scoreboard bench for two sequencer instances (d=2 and d=1)
//               sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_shares_words_sequencer;

    localparam int NB   = 4;
    localparam int MAXW = 8;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       last;
        logic       lw;
        logic       ls;
        logic [3:0] sh;
        logic [3:0] wd;
        logic [7:0] st;
    } obs_t;

    logic clk = 1'b0;
    logic rst, start, abort, inc, mode;
    logic [NB-1:0] bnd;

    logic [NB-1:0]   sh0, wd0, sh1, wd1;
    logic [2*NB-1:0] st0, st1;
    logic lw0, ls0, l0, b0, dn0, lw1, ls1, l1, b1, dn1;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t exp0[$];
    obs_t exp1[$];

    int D[2] = '{2, 1};
    int m_busy[2], m_k[2], m_step[2], m_done[2], m_mode[2], m_B[2];

    always #5 clk = ~clk;

    serial_shares_words_sequencer #(.NBITS(NB), .MAX_WORDS_PER_SHARE(MAXW), .d(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .inc(inc), .mode(mode),
        .words_per_share_bound(bnd), .share_idx(sh0), .word_idx(wd0), .step_cnt(st0),
        .last_word(lw0), .last_share(ls0), .last(l0), .busy(b0), .done(dn0));

    serial_shares_words_sequencer #(.NBITS(NB), .MAX_WORDS_PER_SHARE(MAXW), .d(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .inc(inc), .mode(mode),
        .words_per_share_bound(bnd), .share_idx(sh1), .word_idx(wd1), .step_cnt(st1),
        .last_word(lw1), .last_share(ls1), .last(l1), .busy(b1), .done(dn1));

    // Position k of a sequence maps to (share, word) by division/modulo.
    function automatic obs_t model_obs(input int i);
        obs_t o;
        int   sh, wd, tot;
        tot = D[i] * (m_B[i] + 1);
        sh  = 0;
        wd  = 0;
        if (m_busy[i] != 0) begin
            if (m_mode[i] == 0) begin
                sh = m_k[i] / (m_B[i] + 1);
                wd = m_k[i] % (m_B[i] + 1);
            end else begin
                sh = m_k[i] % D[i];
                wd = m_k[i] / D[i];
            end
        end
        o.busy = (m_busy[i] != 0);
        o.done = (m_done[i] != 0);
        o.lw   = (m_busy[i] != 0) && (wd == m_B[i]);
        o.ls   = (m_busy[i] != 0) && (sh == D[i] - 1);
        o.last = (m_busy[i] != 0) && (m_k[i] == tot - 1);
        o.sh   = 4'(sh);
        o.wd   = 4'(wd);
        o.st   = 8'(m_step[i]);
        return o;
    endfunction

    task automatic model_update(input int i, input logic r, s, a, n, md, input logic [3:0] b);
        int tot;
        tot = D[i] * (m_B[i] + 1);
        if (r) begin
            m_busy[i] = 0; m_k[i] = 0; m_step[i] = 0; m_done[i] = 0; m_mode[i] = 0; m_B[i] = 0;
        end else if (m_busy[i] == 0) begin
            m_done[i] = 0;
            if (s) begin
                m_busy[i] = 1; m_k[i] = 0; m_step[i] = 0; m_mode[i] = int'(md);
                m_B[i]    = (int'(b) > MAXW - 1) ? MAXW - 1 : int'(b);
            end
        end else begin
            m_done[i] = 0;
            if (a) begin
                m_busy[i] = 0; m_k[i] = 0;
            end else if (n) begin
                m_step[i]++;
                if (m_k[i] == tot - 1) begin
                    m_busy[i] = 0; m_k[i] = 0; m_done[i] = 1;
                end else begin
                    m_k[i]++;
                end
            end
        end
    endtask

    task automatic step(input logic r, s, a, n, md, input logic [3:0] b);
        rst = r; start = s; abort = a; inc = n; mode = md; bnd = b;
        model_update(0, r, s, a, n, md, b);
        model_update(1, r, s, a, n, md, b);
        @(posedge clk);
        #1;
        exp0.push_back(model_obs(0));
        exp1.push_back(model_obs(1));
    endtask

    task automatic run_seq(input logic md, input logic [3:0] b);
        step(1'b0, 1'b1, 1'b0, 1'b0, md, b);
        for (int c = 0; c < 200 && (m_busy[0] != 0 || m_busy[1] != 0); c++)
            step(1'b0, 1'b0, 1'b0, 1'b1, md, 4'($urandom_range(0, 15)));
        step(1'b0, 1'b0, 1'b0, 1'b0, md, b);
    endtask

    // Monitor: one observation per cycle per instance, sampled mid-cycle
    initial begin
        obs_t e, got;
        forever begin
            @(negedge clk);
            if (exp0.size() > 0) begin
                e   = exp0.pop_front();
                got = '{b0, dn0, l0, lw0, ls0, sh0, wd0, st0};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL d2_outputs t=%0t got busy=%b done=%b last=%b lw=%b ls=%b sh=%0d wd=%0d st=%0d exp busy=%b done=%b last=%b lw=%b ls=%b sh=%0d wd=%0d st=%0d",
                             $time, got.busy, got.done, got.last, got.lw, got.ls, got.sh, got.wd, got.st,
                             e.busy, e.done, e.last, e.lw, e.ls, e.sh, e.wd, e.st);
                end
            end
            if (exp1.size() > 0) begin
                e   = exp1.pop_front();
                got = '{b1, dn1, l1, lw1, ls1, sh1, wd1, st1};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL d1_outputs t=%0t got busy=%b done=%b last=%b lw=%b ls=%b sh=%0d wd=%0d st=%0d exp busy=%b done=%b last=%b lw=%b ls=%b sh=%0d wd=%0d st=%0d",
                             $time, got.busy, got.done, got.last, got.lw, got.ls, got.sh, got.wd, got.st,
                             e.busy, e.done, e.last, e.lw, e.ls, e.sh, e.wd, e.st);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_k[i] = 0; m_step[i] = 0; m_done[i] = 0; m_mode[i] = 0; m_B[i] = 0;
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; inc = 1'b0; mode = 1'b0; bnd = '0;

        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);

        run_seq(1'b0, 4'd3);
        run_seq(1'b1, 4'd3);
        run_seq(1'b0, 4'd15);
        run_seq(1'b1, 4'd15);

        // start held through the run: accepted again in the done cycle
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        for (int c = 0; c < 30; c++)
            step(1'b0, 1'b1, 1'b0, 1'b1, c[0], 4'($urandom_range(0, 15)));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        for (int c = 0; c < 20 && m_k[0] != 5; c++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        @(negedge clk);
        #1;
        n_checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d pending exp 0/0", exp0.size(), exp1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_shares_words_sequencer.md
SERIAL_SHARES_WORDS_SEQUENCER -- requirements
Module: serial_shares_words_sequencer

Interface
REQ-001 The block SHALL have parameter NBITS, default 4, giving the width of the index and bound ports.
REQ-002 The block SHALL have parameter MAX_WORDS_PER_SHARE, default 8, giving the largest words-per-share count supported, with 1 <= MAX_WORDS_PER_SHARE <= 2^NBITS.
REQ-003 The block SHALL have parameter d, default 2, giving the number of shares, with 1 <= d <= 2^NBITS.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin a sequence; sampled only in IDLE.
REQ-007 abort  input  1  terminate the running sequence without a done pulse.
REQ-008 inc  input  1  advance one step; acted on only in RUN.
REQ-009 mode  input  1  order select, sampled with start: 0 = share-major (word index inner), 1 = word-major (share index inner).
REQ-010 words_per_share_bound  input  NBITS  index of the last word per share (word count minus 1), sampled with start.
REQ-011 share_idx  output  NBITS  current share index.
REQ-012 word_idx  output  NBITS  current word index.
REQ-013 step_cnt  output  2*NBITS  number of inc steps accepted in the current sequence.
REQ-014 last_word, last_share, last  output  1 each  current word is the bound; current share is d-1; both hold while busy.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse after the final step.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-018 In IDLE, start=1 SHALL latch mode and the effective bound, clear share_idx, word_idx and step_cnt, and enter RUN on the next cycle.
REQ-019 The effective bound SHALL be min(words_per_share_bound, MAX_WORDS_PER_SHARE-1).
REQ-020 start SHALL be ignored in RUN, and later changes of mode or words_per_share_bound SHALL have no effect until the next accepted start.
REQ-021 In RUN, inc=1 with last=0 SHALL advance the indices by one step in the latched order and increment step_cnt by 1.
REQ-022 In mode 0, a step SHALL increment word_idx, or, if last_word=1, clear word_idx and increment share_idx.
REQ-023 In mode 1, a step SHALL increment share_idx, or, if last_share=1, clear share_idx and increment word_idx.
REQ-024 In RUN, inc=1 with last=1 SHALL return to IDLE, clear both indices, keep step_cnt at its total of d*(bound+1), and assert done for exactly the following cycle.
REQ-025 The last_word, last_share and last outputs SHALL be combinational from the current indices and the latched bound, gated by busy.
REQ-026 In RUN, abort=1 SHALL take priority over inc, return to IDLE, clear both indices, and produce no done pulse.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 In IDLE, inc SHALL be ignored and the indices SHALL hold 0.
REQ-029 A start in the same cycle as a done pulse SHALL be accepted, giving back-to-back sequences with no gap cycle.
REQ-030 When the effective bound is 0 or d=1, the degenerate dimension SHALL stay 0 and its last_* flag SHALL be constantly 1 while busy.
REQ-031 All index arithmetic SHALL be unsigned with no wrap beyond the bound or d-1.

Reset
REQ-032 rst=1 SHALL force IDLE, with share_idx=0, word_idx=0, step_cnt=0, busy=0, done=0, latched mode=0 and latched bound=0.
REQ-033 rst SHALL take priority over start, abort and inc, including mid-sequence, and SHALL never produce a done pulse.

Verification
REQ-034 Scenario 1: d=2, bound=3, mode=0, inc held high -> (share,word) = (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3); done pulses once; step_cnt=8.
REQ-035 Scenario 2: d=2, bound=3, mode=1 -> (share,word) = (0,0),(1,0),(0,1),(1,1)..(1,3); last asserted only at (1,3).
REQ-036 Scenario 3: bound=15 with MAX_WORDS_PER_SHARE=8 -> word_idx peaks at 7 and 16 steps are taken before done.
REQ-037 Scenario 4: start asserted in the done cycle, with bound changed on the input mid-run -> the second sequence starts immediately, and the first uses the old bound.
REQ-038 Scenario 5: abort at (1,1) together with inc -> IDLE, indices 0, no done; a following rst mid-run also gives all outputs 0.
REQ-039 Scenario 6: bound=0, d=1 -> last=1 on the first busy cycle, and one inc gives done with step_cnt=1.
